// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// FSM state encoding, word geometry and byte-lane mask expansion.
package dmem_pkg;

    localparam int DMEM_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // Expand a 4-bit byte-lane enable into a 32-bit byte mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] mask);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
            m[8*b +: 8] = {8{mask[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage: synchronous byte-masked write port and a
// combinational read port sharing one word address.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    input  logic [3:0]    i_wmask,
    output logic [31:0]   o_rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Byte-masked write; only enabled lanes of the addressed word change.
    // NOTE: storage has no reset -- resetting a RAM forces it into flops and
    // its contents are defined only once software writes them.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DMEM_WORD_BYTES; b++) begin
                if (i_wmask[b]) begin
                    mem_q[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the hart data port: accepts one masked read/write,
// holds it for LATENCY cycles, commits/samples storage on entry to RESP and
// returns data or an error through a backpressured response handshake.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    input  logic        i_rsp_ready
);

    localparam int          AW          = $clog2(DEPTH_WORDS);
    localparam int          CW          = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
    localparam logic [32:0] ADDR_LIMIT  = 33'(DMEM_WORD_BYTES) * 33'(DEPTH_WORDS);
    localparam bit          DIRECT_RESP = (LATENCY == 1);

    dmem_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, addr_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    mask_q, mask_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic [31:0]   eval_addr;
    logic          eval_ren;
    logic          eval_wen;
    logic [31:0]   eval_wdata;
    logic [3:0]    eval_mask;
    logic          eval_err;
    logic          commit;
    logic          arr_we;
    logic [31:0]   arr_rdata;
    logic [31:0]   commit_rdata;

    // Request seen at commit: the live inputs when a single-cycle latency
    // commits on the accept edge, otherwise the latched copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            eval_addr  = i_req_addr;
            eval_ren   = i_req_ren;
            eval_wen   = i_req_wen;
            eval_wdata = i_req_wdata;
            eval_mask  = i_req_mask;
        end else begin
            eval_addr  = addr_q;
            eval_ren   = ren_q;
            eval_wen   = wen_q;
            eval_wdata = wdata_q;
            eval_mask  = mask_q;
        end
    end

    // Illegal requests: bad opcode combination, misaligned, out of range or
    // no lanes enabled. Such requests never touch storage.
    always_comb begin
        eval_err = (eval_ren & eval_wen)
                 | (~eval_ren & ~eval_wen)
                 | (eval_addr[1:0] != 2'b00)
                 | ({1'b0, eval_addr} >= ADDR_LIMIT)
                 | (eval_mask == 4'b0000);
    end

    // Commit fires on the edge that enters RESP; reset blocks it so a write
    // still pending when reset hits never reaches storage.
    always_comb begin
        commit = ~i_rst & (((state_q == ST_WAIT) && (cnt_q == '0))
                        || (DIRECT_RESP && (state_q == ST_IDLE) && i_req_valid));
        arr_we = commit & ~eval_err & eval_wen;
        commit_rdata = (!eval_err && eval_ren) ? (arr_rdata & lane_mask(eval_mask)) : 32'h0;
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .i_clk   (i_clk),
        .i_we    (arr_we),
        .i_addr  (eval_addr[AW+1:2]),
        .i_wdata (eval_wdata),
        .i_wmask (eval_mask),
        .o_rdata (arr_rdata)
    );

    // Next-state logic for the IDLE -> WAIT -> RESP handshake sequence.
    // NOTE: every signal gets its hold value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        ren_d       = ren_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        mask_d      = mask_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    addr_d  = i_req_addr;
                    ren_d   = i_req_ren;
                    wen_d   = i_req_wen;
                    wdata_d = i_req_wdata;
                    mask_d  = i_req_mask;
                    cnt_d   = CNT_LOAD;
                    if (DIRECT_RESP) begin
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = commit_rdata;
                        rsp_err_d   = eval_err;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = commit_rdata;
                    rsp_err_d   = eval_err;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, request latch and registered response outputs.
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= 32'h0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            wdata_q     <= 32'h0;
            mask_q      <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            mask_q      <= mask_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign o_req_ready = (state_q == ST_IDLE) & ~i_rst;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised self-checking bench for dmem_responder: a LATENCY=2 instance
// driven by directed and random traffic with backpressure, and a LATENCY=1
// instance exercised back-to-back. Expected values come from a word-array
// model that applies the request rules directly.
module tb_dmem_responder;

    localparam int DEPTH_A = 1024;
    localparam int LAT_A   = 2;
    localparam int DEPTH_B = 64;
    localparam int LAT_B   = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req_valid, a_req_ready, a_req_ren, a_req_wen;
    logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic [3:0]  a_req_mask;
    logic        a_rsp_valid, a_rsp_err, a_rsp_ready;

    logic        b_rst, b_req_valid, b_req_ready, b_req_ren, b_req_wen;
    logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
    logic [3:0]  b_req_mask;
    logic        b_rsp_valid, b_rsp_err, b_rsp_ready;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_a [DEPTH_A];
    logic [31:0] model_b [DEPTH_B];

    dmem_responder #(.DEPTH_WORDS(DEPTH_A), .LATENCY(LAT_A)) u_dut_a (
        .i_clk       (clk),
        .i_rst       (a_rst),
        .i_req_valid (a_req_valid),
        .o_req_ready (a_req_ready),
        .i_req_addr  (a_req_addr),
        .i_req_ren   (a_req_ren),
        .i_req_wen   (a_req_wen),
        .i_req_wdata (a_req_wdata),
        .i_req_mask  (a_req_mask),
        .o_rsp_valid (a_rsp_valid),
        .o_rsp_rdata (a_rsp_rdata),
        .o_rsp_err   (a_rsp_err),
        .i_rsp_ready (a_rsp_ready)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH_B), .LATENCY(LAT_B)) u_dut_b (
        .i_clk       (clk),
        .i_rst       (b_rst),
        .i_req_valid (b_req_valid),
        .o_req_ready (b_req_ready),
        .i_req_addr  (b_req_addr),
        .i_req_ren   (b_req_ren),
        .i_req_wen   (b_req_wen),
        .i_req_wdata (b_req_wdata),
        .i_req_mask  (b_req_mask),
        .o_rsp_valid (b_rsp_valid),
        .o_rsp_rdata (b_rsp_rdata),
        .o_rsp_err   (b_rsp_err),
        .i_rsp_ready (b_rsp_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit rule_err(input logic [31:0] addr, input bit ren, input bit wen,
                                    input logic [3:0] mask, input int depth);
        return (ren == wen) || (addr % 4 != 0)
            || (longint'(addr) >= 4 * longint'(depth)) || (mask == 4'h0);
    endfunction

    function automatic logic [31:0] pick_lanes(input logic [31:0] w, input logic [3:0] m);
        logic [31:0] r;
        r = 32'h0;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    // Garbage on the request port while busy; must be ignored.
    task automatic a_junk();
        a_req_valid = 1'($urandom_range(0, 1));
        a_req_addr  = $urandom;
        a_req_ren   = 1'($urandom_range(0, 1));
        a_req_wen   = 1'($urandom_range(0, 1));
        a_req_wdata = $urandom;
        a_req_mask  = 4'($urandom);
    endtask

    // One complete transaction on the LATENCY=2 instance with `hold` cycles
    // of response backpressure.
    task automatic a_txn(input logic [31:0] addr, input bit ren, input bit wen,
                         input logic [31:0] wdata, input logic [3:0] mask,
                         input int hold, input string tag);
        bit          exp_err;
        logic [31:0] exp_rd;
        int          lat;
        exp_err = rule_err(addr, ren, wen, mask, DEPTH_A);
        exp_rd  = 32'h0;
        if (!exp_err && ren) exp_rd = pick_lanes(model_a[addr[11:2]], mask);
        if (!exp_err && wen)
            for (int b = 0; b < 4; b++)
                if (mask[b]) model_a[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];

        @(negedge clk);
        check({tag, "_rdy"}, 64'(a_req_ready), 64'(1));
        a_req_valid = 1'b1;
        a_req_addr  = addr;
        a_req_ren   = ren;
        a_req_wen   = wen;
        a_req_wdata = wdata;
        a_req_mask  = mask;
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!a_rsp_valid && lat < 20) begin
            a_junk();
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(LAT_A));
        for (int h = 0; h <= hold; h++) begin
            check({tag, "_rsp"}, {a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata},
                  {1'b1, 1'b0, exp_err, exp_rd});
            if (h < hold) begin
                a_junk();
                @(negedge clk);
            end
        end
        a_req_valid = 1'b0;
        a_rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a_rsp_ready = 1'b0;
        check({tag, "_done"}, {a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata},
              {1'b1 ^ 1'b1, 1'b1, 1'b0, 32'h0});
    endtask

    // One request on the LATENCY=1 instance with valid and rsp_ready held
    // high; called on a negedge where the responder is idle and returns on
    // the negedge where it should be idle again.
    task automatic b_op(input logic [31:0] addr, input bit ren, input bit wen,
                        input logic [31:0] wdata, input logic [3:0] mask, input string tag);
        bit          exp_err;
        logic [31:0] exp_rd;
        exp_err = rule_err(addr, ren, wen, mask, DEPTH_B);
        exp_rd  = 32'h0;
        if (!exp_err && ren) exp_rd = pick_lanes(model_b[addr[7:2]], mask);
        if (!exp_err && wen)
            for (int b = 0; b < 4; b++)
                if (mask[b]) model_b[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
        check({tag, "_rdy"}, 64'(b_req_ready), 64'(1));
        b_req_addr  = addr;
        b_req_ren   = ren;
        b_req_wen   = wen;
        b_req_wdata = wdata;
        b_req_mask  = mask;
        @(negedge clk);
        check({tag, "_rsp"}, {b_rsp_valid, b_req_ready, b_rsp_err, b_rsp_rdata},
              {1'b1, 1'b0, exp_err, exp_rd});
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [31:0] addr;
        bit ren, wen;
        logic [3:0] mask;
        int sel;

        a_rst = 1'b1; b_rst = 1'b1;
        a_req_valid = 1'b0; a_req_addr = '0; a_req_ren = 1'b0; a_req_wen = 1'b0;
        a_req_wdata = '0; a_req_mask = '0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_ren = 1'b0; b_req_wen = 1'b0;
        b_req_wdata = '0; b_req_mask = '0; b_rsp_ready = 1'b0;

        // Reset behaviour.
        @(negedge clk);
        check("rst_hold_a", {a_req_ready, a_rsp_valid}, 64'(0));
        check("rst_hold_b", {b_req_ready, b_rsp_valid}, 64'(0));
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        check("rst_a", {a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata}, {1'b0, 1'b1, 1'b0, 32'h0});
        check("rst_b", {b_rsp_valid, b_req_ready, b_rsp_err, b_rsp_rdata}, {1'b0, 1'b1, 1'b0, 32'h0});

        // Word write/read and byte lanes.
        a_txn(32'h10, 0, 1, 32'hDEADBEEF, 4'hF, 0, "wr_word");
        a_txn(32'h10, 1, 0, 32'h0,        4'hF, 0, "rd_word");
        check("rd_word_model", 64'(model_a[4]), 64'(32'hDEADBEEF));
        a_txn(32'h10, 0, 1, 32'hAB000000, 4'h8, 0, "wr_byte");
        a_txn(32'h10, 1, 0, 32'h0,        4'hF, 0, "rd_full");
        a_txn(32'h10, 1, 0, 32'h0,        4'hC, 0, "rd_hi");

        // Backpressure.
        a_txn(32'h10, 1, 0, 32'h0, 4'hF, 5, "bp");

        // Illegal requests, then confirm storage untouched.
        a_txn(32'h10,      1, 1, 32'h12345678, 4'hF, 0, "err_rw");
        a_txn(32'h10,      0, 0, 32'h12345678, 4'hF, 0, "err_none");
        a_txn(32'h11,      0, 1, 32'h12345678, 4'hF, 0, "err_align");
        a_txn(4 * DEPTH_A, 0, 1, 32'h12345678, 4'hF, 0, "err_range");
        a_txn(32'h10,      0, 1, 32'h12345678, 4'h0, 0, "err_mask");
        a_txn(32'h10,      1, 0, 32'h0,        4'hF, 0, "err_follow");

        // Reset during WAIT drops an uncommitted write.
        a_txn(32'h20, 0, 1, 32'h11111111, 4'hF, 0, "pre_wr");
        @(negedge clk);
        a_req_valid = 1'b1; a_req_addr = 32'h20; a_req_ren = 1'b0; a_req_wen = 1'b1;
        a_req_wdata = 32'h22222222; a_req_mask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        a_rst = 1'b1;
        #1;
        check("rst_wait", {a_rsp_valid, a_req_ready}, 64'(0));
        @(negedge clk);
        a_rst = 1'b0;
        #1;
        check("rst_wait_rel", 64'(a_req_ready), 64'(1));
        a_txn(32'h20, 1, 0, 32'h0, 4'hF, 0, "rd_after_rst");

        // Reset during RESP: the write has already committed.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_addr = 32'h24; a_req_ren = 1'b0; a_req_wen = 1'b1;
        a_req_wdata = 32'h33333333; a_req_mask = 4'hF;
        @(posedge clk);
        @(negedge clk);
        a_req_valid = 1'b0;
        lat = 0;
        while (!a_rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("resp_lat", 64'(lat), 64'(LAT_A));
        a_rst = 1'b1;
        #1;
        check("rst_resp", {a_rsp_valid, a_req_ready, a_rsp_err, a_rsp_rdata}, 64'(0));
        model_a[9] = 32'h33333333;
        @(negedge clk);
        a_rst = 1'b0;
        a_txn(32'h24, 1, 0, 32'h0, 4'hF, 0, "rd_committed");

        // Random traffic over a small known window.
        for (int w = 0; w < 16; w++) a_txn(32'(w * 4), 0, 1, $urandom, 4'hF, 0, "fill");
        for (int i = 0; i < 40; i++) begin
            addr = 32'($urandom_range(0, 15)) << 2;
            ren  = 1'($urandom_range(0, 1));
            wen  = !ren;
            mask = 4'($urandom_range(1, 15));
            sel  = $urandom_range(0, 9);
            case (sel)
                0: addr = addr | 32'($urandom_range(1, 3));
                1: addr = 32'(4 * DEPTH_A) + (32'($urandom_range(0, 255)) << 2);
                2: begin ren = 1; wen = 1; end
                3: begin ren = 0; wen = 0; end
                4: mask = 4'h0;
                default: ;
            endcase
            a_txn(addr, ren, wen, $urandom, mask, $urandom_range(0, 3), "rand");
        end

        // LATENCY=1: back-to-back, one accept every two cycles.
        b_rsp_ready = 1'b1;
        @(negedge clk);
        b_req_valid = 1'b1;
        for (int w = 0; w < 6; w++) b_op(32'(w * 4), 0, 1, $urandom, 4'hF, "b_wr");
        for (int i = 0; i < 8; i++)
            b_op(32'($urandom_range(0, 5)) << 2, 1, 0, 32'h0, 4'($urandom_range(1, 15)), "b_rd");
        b_op(32'h3, 1, 0, 32'h0, 4'hF, "b_err");
        b_req_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
